pktunit_axis_arbiter: RTL

PKTUNIT_AXIS_ARBITER -- requirements
Module: pktunit_axis_arbiter

---
 rtl/pktunit_axis_arbiter_if.sv | 46 ++++
 rtl/pktunit_axis_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pktunit_axis_arbiter_if.sv
// Packet-unit source bundle (all ports) and merged output bundle.
// Sources present N_PORTS packed lanes; the output is one PU stream.
interface pktunit_src_if #(
    parameter int N_PORTS    = 4,
    parameter int DATA_BYTES = 8
);
    logic [N_PORTS*DATA_BYTES*8-1:0] s_data;
    logic [N_PORTS*8-1:0]            s_flags;
    logic [N_PORTS*DATA_BYTES-1:0]   s_eop;
    logic [N_PORTS-1:0]              s_valid;
    logic [N_PORTS-1:0]              s_ready;

    modport master (
        output s_data, s_flags, s_eop, s_valid,
        input  s_ready
    );
    modport slave (
        input  s_data, s_flags, s_eop, s_valid,
        output s_ready
    );
endinterface

interface pktunit_out_if #(
    parameter int DATA_BYTES = 8
);
    logic [DATA_BYTES*8-1:0] m_data_d;
    logic                    m_data_v;
    logic                    m_data_r;
    logic [7:0]              m_flags_d;
    logic                    m_flags_v;
    logic                    m_flags_r;
    logic [DATA_BYTES-1:0]   m_eop_d;
    logic                    m_eop_v;
    logic                    m_eop_r;

    modport master (
        output m_data_d, m_data_v, m_flags_d, m_flags_v,
        output m_eop_d, m_eop_v,
        input  m_data_r, m_flags_r, m_eop_r
    );
    modport slave (
        input  m_data_d, m_data_v, m_flags_d, m_flags_v,
        input  m_eop_d, m_eop_v,
        output m_data_r, m_flags_r, m_eop_r
    );
endinterface

// File: rtl/pktunit_axis_arbiter.sv
// Packet-granular round-robin merge of N PU sources onto one stream
// through a single output register shared by data/flags/eop.
module pktunit_axis_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_BYTES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pktunit_src_if.slave       s_if,
    pktunit_out_if.master      m_if,
    output logic [N_PORTS-1:0] grant,
    output logic [31:0]        pkt_count
);
    localparam int DW = DATA_BYTES * 8;
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_state_nxt;
    logic [N_PORTS-1:0]    r_grant, w_grant_nxt;
    logic [PW-1:0]         r_rr_ptr, w_rr_nxt;
    logic [DW-1:0]         r_data, w_sel_data;
    logic [7:0]            r_flags, w_sel_flags;
    logic [DATA_BYTES-1:0] r_eop, w_sel_eop;
    logic                  r_out_v;
    logic [31:0]           r_pkt_count;
    logic [PW-1:0]         w_gidx, w_idx;
    logic                  w_found;
    logic                  w_out_acc, w_slot_free, w_take;
    logic [N_PORTS-1:0]    w_ready;

    assign w_out_acc   = r_out_v & m_if.m_data_r
                       & m_if.m_flags_r & m_if.m_eop_r;
    assign w_slot_free = !r_out_v | w_out_acc;
    assign w_ready     = (r_state == BUSY && w_slot_free)
                       ? r_grant : '0;
    assign w_take      = |(s_if.s_valid & w_ready);

    // lane of the current owner
    always_comb begin
        w_gidx      = '0;
        w_sel_data  = '0;
        w_sel_flags = '0;
        w_sel_eop   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (r_grant[p]) begin
                w_gidx      = PW'(p);
                w_sel_data  = s_if.s_data[p*DW +: DW];
                w_sel_flags = s_if.s_flags[p*8 +: 8];
                w_sel_eop   = s_if.s_eop[p*DATA_BYTES +: DATA_BYTES];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_found     = 1'b0;
        w_idx       = '0;
        unique case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                for (int i = 0; i < N_PORTS; i++) begin
                    w_idx = PW'((int'(r_rr_ptr) + i) % N_PORTS);
                    if (!w_found && s_if.s_valid[w_idx]) begin
                        w_found            = 1'b1;
                        w_state_nxt        = BUSY;
                        w_grant_nxt[w_idx] = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (w_take && |w_sel_eop) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = PW'((int'(w_gidx) + 1) % N_PORTS);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // new PU wins over drain so back-to-back transfers keep out_v high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_flags <= '0;
            r_eop   <= '0;
            r_out_v <= 1'b0;
        end else if (w_take) begin
            r_data  <= w_sel_data;
            r_flags <= w_sel_flags;
            r_eop   <= w_sel_eop;
            r_out_v <= 1'b1;
        end else if (w_out_acc) begin
            r_out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else if (w_out_acc && |r_eop) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign s_if.s_ready   = w_ready;
    assign m_if.m_data_d  = r_data;
    assign m_if.m_flags_d = r_flags;
    assign m_if.m_eop_d   = r_eop;
    assign m_if.m_data_v  = r_out_v;
    assign m_if.m_flags_v = r_out_v;
    assign m_if.m_eop_v   = r_out_v;
    assign grant          = r_grant;
    assign pkt_count      = r_pkt_count;
endmodule
